// File: rtl/mo_pkg.sv
// Shared types and constants for the motion-object line scanner.
// Holds the FSM state encoding, MO RAM word field positions and default sizes.
package mo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_CHK,
        S_EMIT,
        S_FIN
    } mo_state_t;

    // Each object is two consecutive 16-bit words
    localparam int MO_WORDS = 2;

    // Word0 = {ypos, pic}
    localparam int W0_Y_HI   = 15;
    localparam int W0_Y_LO   = 8;
    localparam int W0_PIC_HI = 7;
    localparam int W0_PIC_LO = 0;

    // Word1 = {xpos, attr}
    localparam int W1_X_HI    = 15;
    localparam int W1_X_LO    = 8;
    localparam int W1_ATTR_HI = 7;
    localparam int W1_ATTR_LO = 0;

    localparam int DEF_NUM_OBJ   = 128;
    localparam int DEF_MO_HEIGHT = 16;
    localparam int DEF_MAX_HITS  = 16;

endpackage

// File: rtl/mo_scan.sv
// Motion-object line scanner: walks MO RAM each hblank and emits hit records.
// Optional per-line hit limit is enabled by defining MO_SCAN_LIMIT_EN.
module mo_scan
    import mo_pkg::*;
#(
    parameter int NUM_OBJ   = DEF_NUM_OBJ,
    parameter int MO_HEIGHT = DEF_MO_HEIGHT,
    parameter int MAX_HITS  = DEF_MAX_HITS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  vline,
    output logic [7:0]  ram_a,
    output logic        ram_r,
    input  logic [15:0] ram_do,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [6:0]  hit_idx,
    output logic [7:0]  hit_pic,
    output logic [3:0]  hit_row,
    output logic [7:0]  hit_x,
    output logic [7:0]  hit_attr,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

`ifdef MO_SCAN_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    mo_state_t   state;
    mo_state_t   state_nxt;
    logic [6:0]  idx;
    logic [7:0]  vline_q;
    logic [15:0] word0_q;
    logic [7:0]  hit_cnt;
    logic [7:0]  ram_a_q;
    logic [7:0]  row;
    logic        hit;
    logic        last;
    logic        lim_hit;

    // Row is the line offset into the object; wraps mod 256 vertically
    assign row     = vline_q - word0_q[W0_Y_HI:W0_Y_LO];
    assign hit     = row < 8'(MO_HEIGHT);
    assign last    = idx == 7'(NUM_OBJ - 1);
    assign lim_hit = LIMIT_EN && (hit_cnt == 8'(MAX_HITS));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs; start always restarts the scan
    always_comb begin
        state_nxt = state;
        ram_a     = ram_a_q;
        ram_r     = 1'b0;
        hit_valid = 1'b0;
        busy      = state != S_IDLE;
        done      = 1'b0;
        unique case (state)
            S_IDLE: state_nxt = S_IDLE;
            S_RD0: begin
                ram_a     = {idx, 1'b0};
                ram_r     = 1'b1;
                state_nxt = S_RD1;
            end
            S_RD1: begin
                ram_a     = {idx, 1'b1};
                ram_r     = 1'b1;
                state_nxt = S_CHK;
            end
            S_CHK: begin
                if (hit) begin
                    state_nxt = lim_hit ? S_FIN : S_EMIT;
                end else begin
                    state_nxt = last ? S_FIN : S_RD0;
                end
            end
            S_EMIT: begin
                hit_valid = 1'b1;
                if (hit_ready) begin
                    state_nxt = last ? S_FIN : S_RD0;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start) begin
            state_nxt = S_RD0;
        end
    end

    // Remember the last video-port address so it holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_a_q <= '0;
        end else if (ram_r) begin
            ram_a_q <= ram_a;
        end
    end

    // Scan counters, word capture and the hit record register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            vline_q  <= '0;
            word0_q  <= '0;
            hit_cnt  <= '0;
            hit_idx  <= '0;
            hit_pic  <= '0;
            hit_row  <= '0;
            hit_x    <= '0;
            hit_attr <= '0;
        end else if (start) begin
            idx     <= '0;
            vline_q <= vline;
            hit_cnt <= '0;
        end else begin
            unique case (state)
                S_RD1: word0_q <= ram_do;
                S_CHK: begin
                    if (hit && !lim_hit) begin
                        hit_idx  <= idx;
                        hit_pic  <= word0_q[W0_PIC_HI:W0_PIC_LO];
                        hit_row  <= row[3:0];
                        hit_x    <= ram_do[W1_X_HI:W1_X_LO];
                        hit_attr <= ram_do[W1_ATTR_HI:W1_ATTR_LO];
                    end else if (!hit && !last) begin
                        idx <= idx + 7'd1;
                    end
                end
                S_EMIT: begin
                    if (hit_ready) begin
                        hit_cnt <= hit_cnt + 8'd1;
                        if (!last) begin
                            idx <= idx + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MO_SCAN_LIMIT_EN
    logic ovf_q;

    // Sticky per-line overflow, cleared by the next start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (start) begin
            ovf_q <= 1'b0;
        end else if (state == S_CHK && hit && lim_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mo_scan.sv
// Scoreboard bench for mo_scan: directed MO RAM images, queued hit records.
// Build with MO_SCAN_LIMIT_EN defined to exercise the per-line hit limit.
module tb_mo_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  vline;
    logic [7:0]  ram_a;
    logic        ram_r;
    logic [15:0] ram_do = '0;
    logic        hit_valid;
    logic        hit_ready;
    logic [6:0]  hit_idx;
    logic [7:0]  hit_pic;
    logic [3:0]  hit_row;
    logic [7:0]  hit_x;
    logic [7:0]  hit_attr;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [15:0] mem [256];
    logic [34:0] q [$];
    int vec = 0;
    int err = 0;

    mo_scan dut (
        .clk(clk), .reset_n(reset_n), .start(start), .vline(vline),
        .ram_a(ram_a), .ram_r(ram_r), .ram_do(ram_do),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_idx(hit_idx), .hit_pic(hit_pic), .hit_row(hit_row),
        .hit_x(hit_x), .hit_attr(hit_attr),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model: data one cycle after the read cycle
    always @(posedge clk) begin
        if (ram_r) ram_do <= mem[ram_a];
    end

    function automatic logic [34:0] rec(input logic [6:0] i, input logic [7:0] p,
                                        input logic [3:0] r, input logic [7:0] x,
                                        input logic [7:0] a);
        return {i, p, r, x, a};
    endfunction

    // Monitor: every accepted record is checked against the queue head
    always @(negedge clk) begin
        if (reset_n && hit_valid && hit_ready) begin
            vec++;
            if (q.size() == 0) begin
                err++;
                $display("FAIL unexpected_hit: got %h, expected none",
                         {hit_idx, hit_pic, hit_row, hit_x, hit_attr});
            end else begin
                logic [34:0] e;
                e = q.pop_front();
                if ({hit_idx, hit_pic, hit_row, hit_x, hit_attr} !== e) begin
                    err++;
                    $display("FAIL hit_record: got %h, expected %h",
                             {hit_idx, hit_pic, hit_row, hit_x, hit_attr}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 0; i < 128; i++) begin
            mem[2*i]   = w0;
            mem[2*i+1] = w1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] v);
        @(negedge clk);
        vline = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            vec++;
            err++;
            $display("FAIL done_timeout: got no done, expected done");
        end
    endtask

    task automatic wait_hit();
        int n;
        n = 0;
        while (!hit_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!hit_valid) begin
            vec++;
            err++;
            $display("FAIL hit_timeout: got no hit_valid, expected hit_valid");
        end
    endtask

    function automatic logic [47:0] outs();
        return {ram_a, ram_r, hit_valid, hit_idx, hit_pic, hit_row,
                hit_x, hit_attr, busy, done, overflow};
    endfunction

    initial begin
        int cyc;
        logic [34:0] snap;
        reset_n   = 1'b0;
        start     = 1'b0;
        vline     = '0;
        hit_ready = 1'b0;
        fill(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 48'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs(), 48'h0);

        // All words zero, vline 0: every object hits on row 0
        hit_ready = 1'b1;
        fill(16'h0000, 16'h0000);
`ifdef MO_SCAN_LIMIT_EN
        for (int i = 0; i < 16; i++) q.push_back(rec(7'(i), 8'h0, 4'h0, 8'h0, 8'h0));
        pulse_start(8'h00);
        wait_done(cyc);
        chk("limit_cycles", cyc, 68);
        chk("limit_overflow", overflow, 1);
        chk("limit_q_empty", q.size(), 0);
        for (int i = 0; i < 16; i++) q.push_back(rec(7'(i), 8'h0, 4'h0, 8'h0, 8'h0));
        pulse_start(8'h00);
        chk("overflow_cleared", overflow, 0);
        wait_done(cyc);
        chk("limit2_overflow", overflow, 1);
        chk("limit2_q_empty", q.size(), 0);
`else
        for (int i = 0; i < 128; i++) q.push_back(rec(7'(i), 8'h0, 4'h0, 8'h0, 8'h0));
        pulse_start(8'h00);
        chk("busy_after_start", busy, 1);
        wait_done(cyc);
        chk("all_hit_cycles", cyc, 513);
        chk("no_overflow", overflow, 0);
        chk("all_hit_q_empty", q.size(), 0);
`endif

        // Single hit at object 5, everything else misses
        fill(16'hF000, 16'h0000);
        mem[10] = 16'h2A11;
        mem[11] = 16'h40C3;
        q.push_back(rec(7'd5, 8'h11, 4'd6, 8'h40, 8'hC3));
        pulse_start(8'h30);
        wait_done(cyc);
        chk("one_hit_cycles", cyc, 386);
        chk("one_hit_q_empty", q.size(), 0);
        @(negedge clk);
        chk("idle_after_done", {busy, done, ram_r}, 3'b000);

        // Same image, consumer stalls for 10 cycles
        hit_ready = 1'b0;
        pulse_start(8'h30);
        wait_hit();
        snap = {hit_idx, hit_pic, hit_row, hit_x, hit_attr};
        chk("stall_first", snap, rec(7'd5, 8'h11, 4'd6, 8'h40, 8'hC3));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", hit_valid, 1);
            chk("stall_stable", {hit_idx, hit_pic, hit_row, hit_x, hit_attr}, snap);
        end
        q.push_back(rec(7'd5, 8'h11, 4'd6, 8'h40, 8'hC3));
        hit_ready = 1'b1;
        wait_done(cyc);
        chk("stall_q_empty", q.size(), 0);

        // Vertical wrap: ypos FA, vline 03 gives row 9
        fill(16'hF000, 16'h0000);
        mem[14] = 16'hFA22;
        mem[15] = 16'h1055;
        q.push_back(rec(7'd7, 8'h22, 4'd9, 8'h10, 8'h55));
        pulse_start(8'h03);
        wait_done(cyc);
        chk("wrap_cycles", cyc, 386);
        chk("wrap_q_empty", q.size(), 0);

        // Reset mid-scan before object 20 is reached
        fill(16'hF000, 16'h0000);
        mem[40] = 16'h0800;
        mem[41] = 16'h1234;
        pulse_start(8'h0A);
        repeat (49) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 48'h0);
        repeat (5) @(negedge clk);
        chk("held_reset_outputs", outs(), 48'h0);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("post_reset_idle", {busy, hit_valid, ram_r}, 3'b000);
        chk("post_reset_q_empty", q.size(), 0);

        // Restart while a hit is pending: old record must vanish
        fill(16'hF000, 16'h0000);
        mem[20] = 16'h08AA;
        mem[21] = 16'h7788;
        mem[6]  = 16'h4E33;
        mem[7]  = 16'h9966;
        hit_ready = 1'b0;
        pulse_start(8'h0A);
        repeat (39) @(negedge clk);
        chk("pending_valid", hit_valid, 1);
        chk("pending_idx", hit_idx, 10);
        pulse_start(8'h50);
        chk("abort_drops_valid", hit_valid, 0);
        chk("abort_ram_a", ram_a, 0);
        q.push_back(rec(7'd3, 8'h33, 4'd2, 8'h99, 8'h66));
        hit_ready = 1'b1;
        wait_done(cyc);
        chk("restart_q_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
